// File: rtl/sha2_msg_schedule_eddsa.sv
// rtl/sha2_msg_schedule_eddsa.sv - SHA-2 message schedule generator using a 16-word shift window
module sha2_msg_schedule_eddsa #(
   parameter int WIDTH = 32,
   parameter int MODE  = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] m_in,
   input  logic             m_valid,
   output logic             m_ready,
   output logic [WIDTH-1:0] w_out,
   output logic [6:0]       w_idx,
   output logic             w_valid,
   input  logic             w_ready,
   output logic             busy,
   output logic             done
);
   localparam bit         LP_WIDE = (MODE == 384) || (MODE == 512);
   localparam logic [6:0] LP_LAST = LP_WIDE ? 7'd79 : 7'd63;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_win [16];
   logic [6:0]       r_cnt;
   logic             r_m_ready;
   logic             r_w_valid;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] w_sig0;
   logic [WIDTH-1:0] w_sig1;
   logic [WIDTH-1:0] w_next;

   // Window taps: reg[1] = W_{t+1}, reg[14] = W_{t+14}, so reg[15] gets W_{t+16}.
   generate
      if (LP_WIDE) begin : g_sig_wide
         assign w_sig0 = {r_win[1][0], r_win[1][WIDTH-1:1]}
                       ^ {r_win[1][7:0], r_win[1][WIDTH-1:8]}
                       ^ (r_win[1] >> 7);
         assign w_sig1 = {r_win[14][18:0], r_win[14][WIDTH-1:19]}
                       ^ {r_win[14][60:0], r_win[14][WIDTH-1:61]}
                       ^ (r_win[14] >> 6);
      end else begin : g_sig_narrow
         assign w_sig0 = {r_win[1][6:0], r_win[1][WIDTH-1:7]}
                       ^ {r_win[1][17:0], r_win[1][WIDTH-1:18]}
                       ^ (r_win[1] >> 3);
         assign w_sig1 = {r_win[14][16:0], r_win[14][WIDTH-1:17]}
                       ^ {r_win[14][18:0], r_win[14][WIDTH-1:19]}
                       ^ (r_win[14] >> 10);
      end
   endgenerate

   assign w_next  = w_sig1 + r_win[9] + w_sig0 + r_win[0];

   assign w_out   = r_win[0];
   assign w_idx   = r_cnt;
   assign m_ready = r_m_ready;
   assign w_valid = r_w_valid;
   assign busy    = r_busy;
   assign done    = r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 7'd0;
         r_m_ready <= 1'b0;
         r_w_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A start landing on the done cycle is dropped; a fresh start is required.
               if (start && !r_done) begin
                  r_state   <= S_LOAD;
                  r_cnt     <= 7'd0;
                  r_m_ready <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            S_LOAD: begin
               if (m_valid && r_m_ready) begin
                  r_win[r_cnt[3:0]] <= m_in;
                  if (r_cnt == 7'd15) begin
                     r_state   <= S_EMIT;
                     r_cnt     <= 7'd0;
                     r_m_ready <= 1'b0;
                     r_w_valid <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 7'd1;
                  end
               end
            end
            S_EMIT: begin
               if (w_ready) begin
                  for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                  r_win[15] <= w_next;
                  if (r_cnt == LP_LAST) begin
                     r_state   <= S_IDLE;
                     r_cnt     <= 7'd0;
                     r_w_valid <= 1'b0;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 7'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha2_msg_schedule_eddsa.sv
// tb/tb_sha2_msg_schedule_eddsa.sv - scoreboard bench for sha2_msg_schedule_eddsa (MODE 256 and 512)
module tb_sha2_msg_schedule_eddsa;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        start;
   logic        m_valid;
   logic        w_ready;
   logic [63:0] m_in;

   logic        a_m_ready, a_w_valid, a_busy, a_done;
   logic [31:0] a_w_out;
   logic [6:0]  a_w_idx;
   logic        b_m_ready, b_w_valid, b_busy, b_done;
   logic [63:0] b_w_out;
   logic [6:0]  b_w_idx;

   logic        m_ready_m, w_valid_m, busy_m, done_m;
   logic [63:0] w_out_m;
   logic [6:0]  w_idx_m;

   typedef struct packed {
      logic [6:0]  idx;
      logic [63:0] word;
   } exp_t;

   exp_t        q [$];
   logic [63:0] cap [80];
   logic [63:0] abc256 [16];
   logic [63:0] abc512 [16];
   logic [63:0] blk [16];
   int          n_vec = 0;
   int          n_err = 0;
   int          hs_count = 0;
   int          emit_cycles = 0;
   int          stalls;

   always #5 clk = ~clk;

   sha2_msg_schedule_eddsa #(.WIDTH(32), .MODE(256)) u_dut_256 (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel), .m_in(m_in[31:0]),
      .m_valid(m_valid & ~sel), .m_ready(a_m_ready), .w_out(a_w_out), .w_idx(a_w_idx),
      .w_valid(a_w_valid), .w_ready(w_ready), .busy(a_busy), .done(a_done)
   );

   sha2_msg_schedule_eddsa #(.WIDTH(64), .MODE(512)) u_dut_512 (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .m_in(m_in),
      .m_valid(m_valid & sel), .m_ready(b_m_ready), .w_out(b_w_out), .w_idx(b_w_idx),
      .w_valid(b_w_valid), .w_ready(w_ready), .busy(b_busy), .done(b_done)
   );

   assign m_ready_m = sel ? b_m_ready : a_m_ready;
   assign w_valid_m = sel ? b_w_valid : a_w_valid;
   assign busy_m    = sel ? b_busy    : a_busy;
   assign done_m    = sel ? b_done    : a_done;
   assign w_out_m   = sel ? b_w_out   : {32'd0, a_w_out};
   assign w_idx_m   = sel ? b_w_idx   : a_w_idx;

   function automatic logic [63:0] msk(input int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
      return ((x >> n) | (x << (w - n))) & msk(w);
   endfunction

   function automatic logic [63:0] sg0(input logic [63:0] x, input int w);
      if (w == 64) return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
      return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
   endfunction

   function automatic logic [63:0] sg1(input logic [63:0] x, input int w);
      if (w == 64) return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
      return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted output word.
   logic        prev_stall = 1'b0;
   logic [63:0] prev_out;
   logic [6:0]  prev_idx;
   logic        exp_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
         exp_done   = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_hold_w_out", w_out_m, prev_out);
            check("stall_hold_w_idx", 64'(w_idx_m), 64'(prev_idx));
         end
         if (done_m || exp_done) check("done_pulse", 64'(done_m), 64'(exp_done));
         exp_done = 1'b0;
         if (w_valid_m) emit_cycles++;
         if (w_valid_m && w_ready) begin
            if (q.size() == 0) begin
               check("unexpected_word", 64'(w_idx_m), 64'h7F);
            end else begin
               e = q.pop_front();
               check("w_idx", 64'(w_idx_m), 64'(e.idx));
               check("w_out", w_out_m, e.word);
               cap[w_idx_m] = w_out_m;
               hs_count++;
               if (e.idx == (sel ? 7'd79 : 7'd63)) exp_done = 1'b1;
            end
         end
         prev_stall = w_valid_m && !w_ready;
         prev_out   = w_out_m;
         prev_idx   = w_idx_m;
      end
   end

   task automatic load_block(input logic [63:0] b [16], input int gap, input bit poke);
      logic [63:0] W [80];
      exp_t        e;
      int          w, r, t;
      w = sel ? 64 : 32;
      r = sel ? 80 : 64;
      for (int i = 0; i < 16; i++) W[i] = b[i] & msk(w);
      for (int i = 16; i < r; i++)
         W[i] = (sg1(W[i-2], w) + W[i-7] + sg0(W[i-15], w) + W[i-16]) & msk(w);
      for (int i = 0; i < r; i++) begin
         e.idx  = 7'(i);
         e.word = W[i];
         q.push_back(e);
      end
      if (poke) begin
         m_in    = 64'hDEAD_BEEF_0BAD_F00D;
         m_valid = 1'b1;
         repeat (3) begin
            @(posedge clk); #1;
            check("m_ready_idle", 64'(m_ready_m), 64'd0);
         end
         m_valid = 1'b0;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (gap > 0) begin
            m_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
         end
         m_in    = b[i];
         m_valid = 1'b1;
         start   = poke && (i == 5 || i == 10);
         t = 0;
         while (!m_ready_m && t < 100) begin @(posedge clk); #1; t++; end
         if (t >= 100) check("load_timeout", 64'(m_ready_m), 64'd1);
         if (i == 15) check("w_valid_before_last", 64'(w_valid_m), 64'd0);
         @(posedge clk); #1;
         start = 1'b0;
      end
      m_valid = 1'b0;
      check("first_w_valid", 64'(w_valid_m), 64'd1);
   endtask

   task automatic emit_block(input int stall_mode, input int abort_idx, input bit poke,
                             output int n_stall);
      int cyc;
      cyc     = 0;
      n_stall = 0;
      while (w_valid_m && cyc < 1000) begin
         case (stall_mode)
            0:       w_ready = 1'b1;
            1:       w_ready = (cyc % 3 == 0);
            default: w_ready = ($urandom % 2) == 0;
         endcase
         if (poke) begin
            start = (cyc == 10);
            check("m_ready_emit", 64'(m_ready_m), 64'd0);
         end
         if (!w_ready) n_stall++;
         if (abort_idx >= 0 && w_idx_m == 7'(abort_idx)) begin
            #2 rst_n = 1'b0;
            #1;
            check("abort_flags", 64'({w_valid_m, m_ready_m, busy_m, done_m}), 64'd0);
            check("abort_w_out", w_out_m, 64'd0);
            check("abort_w_idx", 64'(w_idx_m), 64'd0);
            q.delete();
            @(posedge clk); #3 rst_n = 1'b1;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      if (cyc >= 1000) check("emit_timeout", 64'(w_valid_m), 64'd0);
      start   = 1'b0;
      w_ready = 1'b1;
   endtask

   task automatic rand_block();
      for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; sel = 1'b0; start = 1'b0; m_valid = 1'b0; w_ready = 1'b1; m_in = 64'd0;
      for (int i = 0; i < 16; i++) begin abc256[i] = 64'd0; abc512[i] = 64'd0; end
      abc256[0]  = 64'h0000_0000_6162_6380;
      abc256[15] = 64'h0000_0000_0000_0018;
      abc512[0]  = 64'h6162_6380_0000_0000;
      abc512[15] = 64'h0000_0000_0000_0018;
      repeat (2) @(posedge clk);
      #1;
      check("reset_flags_256", 64'({a_w_valid, a_m_ready, a_busy, a_done}), 64'd0);
      check("reset_out_256", {25'd0, a_w_idx, a_w_out}, 64'd0);
      check("reset_flags_512", 64'({b_w_valid, b_m_ready, b_busy, b_done}), 64'd0);
      check("reset_out_512", b_w_out | 64'(b_w_idx), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // abc block, MODE 256, free-running consumer, then start on the done cycle.
      hs_count = 0;
      load_block(abc256, 0, 1'b0);
      emit_block(0, -1, 1'b0, stalls);
      check("done_now", 64'(done_m), 64'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_on_done_lost", 64'({m_ready_m, busy_m}), 64'd0);
      check("count_256", 64'(hs_count), 64'd64);
      check("abc_w16", cap[16], 64'h6162_6380);
      check("abc_w17", cap[17], 64'h000F_0000);
      check("abc_w18", cap[18], 64'h7DA8_6405);

      // Same block with 1,0,0 back-pressure.
      hs_count = 0; emit_cycles = 0;
      load_block(abc256, 0, 1'b0);
      emit_block(1, -1, 1'b0, stalls);
      @(posedge clk); #1;
      check("count_256_stall", 64'(hs_count), 64'd64);
      check("emit_cycles", 64'(emit_cycles), 64'(64 + stalls));

      // abc block, MODE 512.
      sel = 1'b1; hs_count = 0;
      load_block(abc512, 0, 1'b0);
      emit_block(0, -1, 1'b0, stalls);
      @(posedge clk); #1;
      check("count_512", 64'(hs_count), 64'd80);
      check("abc512_w16", cap[16], abc512[0]);
      check("abc512_w17", cap[17], sg1(64'h18, 64));

      // Gapped input stream.
      sel = 1'b0; hs_count = 0;
      rand_block();
      load_block(blk, 3, 1'b0);
      emit_block(2, -1, 1'b0, stalls);
      @(posedge clk); #1;
      check("count_gap", 64'(hs_count), 64'd64);

      // Reset at w_idx=30, then a clean reload.
      rand_block();
      load_block(blk, 0, 1'b0);
      emit_block(0, 30, 1'b0, stalls);
      repeat (3) begin
         @(posedge clk); #1;
         check("no_done_after_abort", 64'({done_m, busy_m}), 64'd0);
      end
      hs_count = 0;
      rand_block();
      load_block(blk, 0, 1'b0);
      emit_block(2, -1, 1'b0, stalls);
      @(posedge clk); #1;
      check("count_reload", 64'(hs_count), 64'd64);

      // Spurious start / m_valid outside their states, MODE 512.
      sel = 1'b1; hs_count = 0;
      rand_block();
      load_block(blk, 0, 1'b1);
      emit_block(0, -1, 1'b1, stalls);
      @(posedge clk); #1;
      check("count_poke", 64'(hs_count), 64'd80);

      // Random blocks in both modes with random back-pressure and gaps.
      for (int k = 0; k < 4; k++) begin
         sel = k[0]; hs_count = 0;
         rand_block();
         load_block(blk, k % 3, 1'b0);
         emit_block(2, -1, 1'b0, stalls);
         @(posedge clk); #1;
         check("count_rand", 64'(hs_count), sel ? 64'd80 : 64'd64);
      end
      check("queue_empty", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sha2_msg_schedule_eddsa.md
Name: sha2_msg_schedule_eddsa

Overview:
Producer side of the SHA-2 compression datapath. It accepts one 512/1024-bit message block as 16 words over a valid/ready input stream, then emits the full message schedule W_0..W_{R-1}, one word per accepted output handshake, to the round controller driving sha2_round_eddsa's W input. It uses a 16-word shift window and supports SHA-224/256 (32-bit words, 64 rounds) and SHA-384/512 (64-bit words, 80 rounds).

Parameters:
WIDTH, 32, word width; 32 for MODE 224/256, 64 for MODE 384/512.
MODE, 256, SHA-2 variant (224, 256, 384, 512); selects the sigma functions and the round count R (64 for 224/256, 80 for 384/512).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse that begins a block; honoured only in IDLE.
m_in  input  WIDTH  message word, big-endian word order M_0 first.
m_valid  input  1  m_in valid.
m_ready  output  1  block accepts m_in (high only in LOAD).
w_out  output  WIDTH  current schedule word W_t, registered.
w_idx  output  7  index t of w_out.
w_valid  output  1  w_out/w_idx valid (high only in EMIT).
w_ready  input  1  consumer accepts W_t.
busy  output  1  high in LOAD or EMIT.
done  output  1  one-cycle pulse after W_{R-1} is accepted.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; window regs, counter, w_idx=0; m_ready=0, w_valid=0, busy=0, done=0; w_out=0.
- Window reg[0..15] with reg[0]=W_t; w_out=reg[0].
- States:
  - IDLE: start=1 -> LOAD, cnt=0. start is ignored in every other state.
  - LOAD: m_ready=1. On m_valid&m_ready, reg[cnt]<=m_in and cnt++. The accept with cnt=15 -> EMIT, cnt=0.
  - EMIT: w_valid=1, w_idx=cnt. On w_valid&w_ready, the window shifts: reg[i]<=reg[i+1] for i=0..14, reg[15]<=sig1(reg[14])+reg[9]+sig0(reg[1])+reg[0], cnt++. The accept with cnt=R-1 -> IDLE, with done=1 for exactly the next cycle.
- The recurrence is uniform for all t: W_0..W_15 emerge unmodified, and W_t for t>=16 comes from the window.
- Arithmetic: all additions modulo 2^WIDTH; carries discarded.
- Sigma functions, MODE 224/256: sig0=ROTR7^ROTR18^SHR3; sig1=ROTR17^ROTR19^SHR10.
- Sigma functions, MODE 384/512: sig0=ROTR1^ROTR8^SHR7; sig1=ROTR19^ROTR61^SHR6.
- Latency: w_valid rises the cycle after the 16th input handshake. With w_ready held high, the block emits one word per cycle: R cycles in EMIT, then done.
- Back-pressure: while w_valid=1 and w_ready=0, w_out, w_idx and the window are held stable.
- LOAD stalls indefinitely while m_valid=0, with no timeout.
- m_valid outside LOAD is ignored (m_ready=0).
- start coincident with done returns to IDLE first; the start is lost, and a new start is needed the cycle after.
- Reset mid-LOAD or mid-EMIT aborts immediately to IDLE with no done pulse; partial data is discarded.
- w_idx wraps internally only via return to IDLE, never beyond R-1.

Test Plan:
1. MODE=256, "abc" padded block (M_0=0x61626380, M_1..M_14=0, M_15=0x00000018), w_ready=1 -> W_0..W_15 equal the inputs; W_16=0x61626380, W_17=0x000F0000, W_18=0x7DA86405; 64 words total; done pulses once, one cycle after w_idx=63 is accepted.
2. Same block with w_ready toggled 1,0,0,1,... -> identical W sequence; w_out/w_idx stable during stalls; total EMIT cycles = 64 + stall count.
3. MODE=512, WIDTH=64, "abc" padded block (M_0=0x6162638000000000, M_15=0x18) -> W_0..W_15 match the inputs; 80 words emitted; W_16=M_0; W_17=sig1_512(0x18) per the MODE 384/512 sigma definition, computed in the bench model; done after w_idx=79.
4. m_valid gaps of 3 cycles between words during LOAD -> no word skipped or duplicated; first w_valid comes 1 cycle after the 16th accept.
5. rst_n low for 1 cycle at w_idx=30 -> all outputs 0 asynchronously, with no done; a new start followed by a reload yields the correct schedule from W_0.
6. start pulsed during LOAD and during EMIT, and m_valid high in IDLE -> no state or data disturbance; m_ready stays 0 outside LOAD.
